// File: rtl/cvxif_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cvxif_resp_pkg
// Brief    : Shared constants, types and decode for the CV-X-IF responder.
//            MUL decode is enabled by defining CVXIF_RESP_MUL_EN.
// Revision : 1.0
// ============================================================================
package cvxif_resp_pkg;

  localparam logic [6:0] OPCODE_CUSTOM0 = 7'h0B;
  localparam logic [6:0] FUNCT7_BASE    = 7'h00;
  localparam logic [2:0] F3_ADD         = 3'b000;
  localparam logic [2:0] F3_SUB         = 3'b001;
  localparam logic [2:0] F3_MUL         = 3'b010;
  localparam logic [2:0] F3_NOP         = 3'b011;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_NOP = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } fsm_e;

  typedef struct packed {
    op_e        op;
    logic [4:0] rd;
    logic       committed;
    logic       killed;
  } entry_t;

  // Returns 1 when the word is an encoding this unit executes.
  function automatic logic decode_instr(input logic [31:0] instr, output op_e op);
    logic legal;
    legal = 1'b0;
    op    = OP_NOP;
    if (instr[6:0] == OPCODE_CUSTOM0 && instr[31:25] == FUNCT7_BASE) begin
      case (instr[14:12])
        F3_ADD: begin op = OP_ADD; legal = 1'b1; end
        F3_SUB: begin op = OP_SUB; legal = 1'b1; end
`ifdef CVXIF_RESP_MUL_EN
        F3_MUL: begin op = OP_MUL; legal = 1'b1; end
`else
        F3_MUL: legal = 1'b0;
`endif
        F3_NOP: begin op = OP_NOP; legal = 1'b1; end
        default: legal = 1'b0;
      endcase
    end
    return legal;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cvxif_resp_alu.sv
`default_nettype none
// ============================================================================
// Module   : cvxif_resp_alu
// Brief    : ADD/SUB in one cycle; MUL over MulLatency cycles when
//            CVXIF_RESP_MUL_EN is defined. Result is held until the next start.
// Revision : 1.0
// ============================================================================
module cvxif_resp_alu
  import cvxif_resp_pkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned MulLatency = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] data_q, data_d;
  logic [XLEN-1:0] sum;

  assign sum = (op_i == OP_SUB) ? (a_i - b_i) : (a_i + b_i);

`ifdef CVXIF_RESP_MUL_EN
  localparam int unsigned CntW = $clog2(MulLatency + 1);

  logic            busy_q, busy_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] ma_q, mb_q;

  // done fires in the cycle before the product lands in data_q
  always_comb begin
    done_o = 1'b0;
    data_d = data_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (busy_q) begin
      if (cnt_q == CntW'(1)) begin
        done_o = 1'b1;
        data_d = ma_q * mb_q;
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CntW'(1);
      end
    end else if (start_i) begin
      if (op_i != OP_MUL) begin
        done_o = 1'b1;
        data_d = sum;
      end else if (MulLatency == 1) begin
        done_o = 1'b1;
        data_d = a_i * b_i;
      end else begin
        busy_d = 1'b1;
        cnt_d  = CntW'(MulLatency - 1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      ma_q   <= '0;
      mb_q   <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      if (start_i && !busy_q) begin
        ma_q <= a_i;
        mb_q <= b_i;
      end
    end
  end
`else
  always_comb begin
    done_o = start_i;
    data_d = start_i ? sum : data_q;
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) data_q <= '0;
    else       data_q <= data_d;
  end

  assign data_o = data_q;

  a_mul_latency: assert property (@(posedge clk_i) MulLatency >= 1);

endmodule
`default_nettype wire

// File: rtl/cvxif_resp_unit.sv
`default_nettype none
// ============================================================================
// Module   : cvxif_resp_unit
// Brief    : CV-X-IF coprocessor responder: in-order buffer, commit/kill,
//            execute and result return. MUL enabled by CVXIF_RESP_MUL_EN.
// Revision : 1.0
// ============================================================================
module cvxif_resp_unit
  import cvxif_resp_pkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned IdWidth    = 3,
  parameter int unsigned Depth      = 4,
  parameter int unsigned MulLatency = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [31:0]        issue_instr_i,
  input  logic [XLEN-1:0]    issue_rs1_i,
  input  logic [XLEN-1:0]    issue_rs2_i,
  input  logic [IdWidth-1:0] issue_id_i,
  output logic               issue_accept_o,
  output logic               issue_writeback_o,
  input  logic               commit_valid_i,
  input  logic [IdWidth-1:0] commit_id_i,
  input  logic               commit_kill_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [XLEN-1:0]    result_data_o,
  output logic [4:0]         result_rd_o,
  output logic               result_we_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  fsm_e               state_q, state_d;
  entry_t             entries_q [Depth];
  logic [IdWidth-1:0] id_q      [Depth];
  logic [XLEN-1:0]    rs1_q     [Depth];
  logic [XLEN-1:0]    rs2_q     [Depth];
  logic [Depth-1:0]   valid_q;
  logic [PtrW-1:0]    head_q, tail_q;
  logic [CntW-1:0]    count_q;

  op_e              dec_op;
  logic             dec_legal;
  logic             push, pop, alu_start, alu_done;
  logic [Depth-1:0] hit;
  logic             head_committed, head_killed;
  logic [XLEN-1:0]  alu_data;
  entry_t           head;

  always_comb begin
    dec_op    = OP_NOP;
    dec_legal = decode_instr(issue_instr_i, dec_op);
  end

  // Ready looks only at the registered count, so a same-cycle pop never frees a slot early.
  assign issue_ready_o     = (count_q != CntW'(Depth)) && !rst_i;
  assign push              = issue_valid_i && issue_ready_o && dec_legal;
  assign issue_accept_o    = push;
  assign issue_writeback_o = push && (dec_op != OP_NOP);

  always_comb begin
    for (int i = 0; i < Depth; i++) begin
      hit[i] = commit_valid_i && valid_q[i] && (id_q[i] == commit_id_i);
    end
  end

  // Head decisions also see this cycle's strobe so ADD/SUB answer one cycle after commit.
  assign head           = entries_q[head_q];
  assign head_committed = head.committed || (hit[head_q] && !commit_kill_i);
  assign head_killed    = head.killed    || (hit[head_q] && commit_kill_i);

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    alu_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_q[head_q]) begin
          if (head_killed) begin
            pop = 1'b1;
          end else if (head_committed) begin
            if (head.op == OP_NOP) begin
              pop = 1'b1;
            end else begin
              alu_start = 1'b1;
              state_d   = alu_done ? RESP : EXEC;
            end
          end
        end
      end
      EXEC: begin
        if (alu_done) state_d = RESP;
      end
      RESP: begin
        if (result_ready_i) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  cvxif_resp_alu #(
    .XLEN       (XLEN),
    .MulLatency (MulLatency)
  ) u_alu (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (alu_start),
    .op_i    (head.op),
    .a_i     (rs1_q[head_q]),
    .b_i     (rs2_q[head_q]),
    .done_o  (alu_done),
    .data_o  (alu_data)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PtrW'(1);
      end
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PtrW'(1);
      end
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Payload is qualified by valid_q and needs no reset.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < Depth; i++) begin
      if (hit[i]) begin
        if (commit_kill_i) entries_q[i].killed    <= 1'b1;
        else               entries_q[i].committed <= 1'b1;
      end
    end
    if (push) begin
      entries_q[tail_q] <= '{op: dec_op, rd: issue_instr_i[11:7], committed: 1'b0, killed: 1'b0};
      id_q[tail_q]      <= issue_id_i;
      rs1_q[tail_q]     <= issue_rs1_i;
      rs2_q[tail_q]     <= issue_rs2_i;
    end
  end

  assign result_valid_o = (state_q == RESP);
  assign result_we_o    = result_valid_o;
  assign result_id_o    = result_valid_o ? id_q[head_q] : '0;
  assign result_rd_o    = result_valid_o ? head.rd : '0;
  assign result_data_o  = result_valid_o ? alu_data : '0;

  a_commit_known: assert property (@(posedge clk_i) disable iff (rst_i)
    commit_valid_i |-> (|hit));
  a_no_issue_commit_race: assert property (@(posedge clk_i) disable iff (rst_i)
    !(commit_valid_i && push && (issue_id_i == commit_id_i)));

endmodule
`default_nettype wire

// File: tb/tb_cvxif_resp_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cvxif_resp_unit
// Brief    : Scoreboard bench for cvxif_resp_unit (MUL path under CVXIF_RESP_MUL_EN).
// Revision : 1.0
// ============================================================================
module tb_cvxif_resp_unit;

  localparam int XLEN    = 64;
  localparam int IDW     = 3;
  localparam int DEPTH   = 4;
  localparam int MUL_LAT = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            issue_valid_i, issue_ready_o;
  logic [31:0]     issue_instr_i;
  logic [XLEN-1:0] issue_rs1_i, issue_rs2_i;
  logic [IDW-1:0]  issue_id_i;
  logic            issue_accept_o, issue_writeback_o;
  logic            commit_valid_i, commit_kill_i;
  logic [IDW-1:0]  commit_id_i;
  logic            result_valid_o, result_ready_i;
  logic [IDW-1:0]  result_id_o;
  logic [XLEN-1:0] result_data_o;
  logic [4:0]      result_rd_o;
  logic            result_we_o;

  always #5 clk = ~clk;

  cvxif_resp_unit #(
    .XLEN(XLEN), .IdWidth(IDW), .Depth(DEPTH), .MulLatency(MUL_LAT)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_instr_i(issue_instr_i), .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
    .issue_id_i(issue_id_i), .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i), .result_id_o(result_id_o),
    .result_data_o(result_data_o), .result_rd_o(result_rd_o), .result_we_o(result_we_o)
  );

  typedef struct {
    logic [IDW-1:0] id;
    logic [63:0]    data;
    logic [4:0]     rd;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  logic [2:0]  tv_f3 [4] = '{3'b000, 3'b001, 3'b001, 3'b000};
  logic [63:0] tv_a  [4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF};
  logic [63:0] tv_b  [4] = '{64'd1, 64'd5, 64'd1, 64'd1};
  logic [63:0] tv_y  [4] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF,
                             64'h8000_0000_0000_0000};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [2:0] f3, input logic [4:0] rd);
    return {7'h00, 5'd2, 5'd1, f3, rd, 7'h0B};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [63:0] a, input logic [63:0] b,
                       input logic [IDW-1:0] id, input logic acc, input logic wb);
    int n;
    n = 0;
    issue_valid_i = 1'b1;
    issue_instr_i = instr;
    issue_rs1_i   = a;
    issue_rs2_i   = b;
    issue_id_i    = id;
    #1;
    while (!issue_ready_o && n < 50) begin
      tick();
      n++;
      #1;
    end
    chk("issue_ready", issue_ready_o, 1'b1);
    chk("issue_accept", issue_accept_o, acc);
    chk("issue_writeback", issue_writeback_o, wb);
    tick();
    issue_valid_i = 1'b0;
  endtask

  task automatic commit(input logic [IDW-1:0] id, input logic kill, input logic res,
                        input logic [63:0] data, input logic [4:0] rd);
    commit_valid_i = 1'b1;
    commit_id_i    = id;
    commit_kill_i  = kill;
    if (res) exp_q.push_back('{id: id, data: data, rd: rd});
    tick();
    commit_valid_i = 1'b0;
    commit_kill_i  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    tick();
  endtask

  always @(negedge clk) begin
    if (!rst && result_valid_o && result_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("spurious_result_valid", result_valid_o, 1'b0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_id", result_id_o, e.id);
        chk("res_data", result_data_o, e.data);
        chk("res_rd", result_rd_o, e.rd);
        chk("res_we", result_we_o, 1'b1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1;
    issue_valid_i = 1'b0; issue_instr_i = '0; issue_rs1_i = '0; issue_rs2_i = '0; issue_id_i = '0;
    commit_valid_i = 1'b0; commit_id_i = '0; commit_kill_i = 1'b0;
    result_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    issue_valid_i = 1'b1;
    issue_instr_i = enc(3'b000, 5'd1);
    #1;
    chk("rst_issue_ready", issue_ready_o, 1'b0);
    chk("rst_accept", issue_accept_o, 1'b0);
    chk("rst_result_valid", result_valid_o, 1'b0);
    issue_valid_i = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", issue_ready_o, 1'b1);
    tick();

    // ADD with single-cycle result latency
    issue(enc(3'b000, 5'd3), 64'd5, 64'd7, 3'd1, 1'b1, 1'b1);
    tick();
    chk("t1_valid_before_commit", result_valid_o, 1'b0);
    commit(3'd1, 1'b0, 1'b1, 64'd12, 5'd3);
    chk("t1_valid_after_commit", result_valid_o, 1'b1);
    chk("t1_id_after_commit", result_id_o, 3'd1);
    tick();
    chk("t1_valid_cleared", result_valid_o, 1'b0);

    // rejected encodings
    issue({7'h00, 10'h0, 3'b111, 5'd4, 7'h0B}, 64'd1, 64'd2, 3'd2, 1'b0, 1'b0);
    issue({7'h20, 10'h0, 3'b000, 5'd4, 7'h0B}, 64'd1, 64'd2, 3'd2, 1'b0, 1'b0);
    issue({7'h00, 10'h0, 3'b000, 5'd4, 7'h33}, 64'd1, 64'd2, 3'd2, 1'b0, 1'b0);
    repeat (3) tick();

    // kill then commit
    issue(enc(3'b001, 5'd4), 64'd3, 64'd5, 3'd2, 1'b1, 1'b1);
    issue(enc(3'b000, 5'd5), 64'd10, 64'd20, 3'd3, 1'b1, 1'b1);
    commit(3'd2, 1'b1, 1'b0, 64'd0, 5'd0);
    commit(3'd3, 1'b0, 1'b1, 64'd30, 5'd5);
    drain();

    // NOP produces no result and does not block later entries
    issue(enc(3'b011, 5'd0), 64'd0, 64'd0, 3'd4, 1'b1, 1'b0);
    issue(enc(3'b000, 5'd6), 64'd100, 64'd23, 3'd5, 1'b1, 1'b1);
    commit(3'd4, 1'b0, 1'b0, 64'd0, 5'd0);
    commit(3'd5, 1'b0, 1'b1, 64'd123, 5'd6);
    drain();

    // wrap-around arithmetic
    for (int i = 0; i < 4; i++)
      issue(enc(tv_f3[i], 5'(i + 8)), tv_a[i], tv_b[i], 3'(i), 1'b1, 1'b1);
    for (int i = 0; i < 4; i++)
      commit(3'(i), 1'b0, 1'b1, tv_y[i], 5'(i + 8));
    drain();

    // full buffer holds the next request until a pop
    for (int i = 0; i < DEPTH; i++)
      issue(enc(3'b000, 5'(i + 1)), 64'(10 * i), 64'(i), 3'(i), 1'b1, 1'b1);
    #1;
    chk("t4_full_ready", issue_ready_o, 1'b0);
    issue_valid_i = 1'b1;
    issue_instr_i = enc(3'b000, 5'd5);
    issue_rs1_i   = 64'd40;
    issue_rs2_i   = 64'd4;
    issue_id_i    = 3'd4;
    repeat (3) begin
      tick();
      #1;
      chk("t4_held_ready", issue_ready_o, 1'b0);
      chk("t4_held_accept", issue_accept_o, 1'b0);
    end
    tick();
    commit(3'd0, 1'b0, 1'b1, 64'd0, 5'd1);
    chk("t4_pop_cycle_ready", issue_ready_o, 1'b0);
    issue(enc(3'b000, 5'd5), 64'd40, 64'd4, 3'd4, 1'b1, 1'b1);
    for (int i = 1; i <= DEPTH; i++)
      commit(3'(i), 1'b0, 1'b1, 64'(11 * i), 5'(i + 1));
    drain();

`ifdef CVXIF_RESP_MUL_EN
    result_ready_i = 1'b0;
    issue(enc(3'b010, 5'd7), 64'd6, 64'd7, 3'd0, 1'b1, 1'b1);
    commit(3'd0, 1'b0, 1'b1, 64'd42, 5'd7);
    n = 0;
    while (!result_valid_o && n < 20) begin
      tick();
      n++;
    end
    chk("t5_mul_latency", n, MUL_LAT - 1);
    repeat (5) begin
      tick();
      chk("t5_hold_valid", result_valid_o, 1'b1);
      chk("t5_hold_data", result_data_o, 64'd42);
      chk("t5_hold_rd", result_rd_o, 5'd7);
    end
    result_ready_i = 1'b1;
    drain();
`else
    issue(enc(3'b010, 5'd7), 64'd6, 64'd7, 3'd0, 1'b0, 1'b0);
    repeat (3) tick();
`endif

    // reset while a result is pending
    result_ready_i = 1'b0;
    issue(enc(3'b000, 5'd9), 64'd1, 64'd2, 3'd6, 1'b1, 1'b1);
    commit(3'd6, 1'b0, 1'b1, 64'd3, 5'd9);
    chk("t6_in_resp", result_valid_o, 1'b1);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", result_valid_o, 1'b0);
    chk("t6_rst_ready", issue_ready_o, 1'b0);
    chk("t6_rst_data", result_data_o, 64'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    result_ready_i = 1'b1;
    #1;
    chk("t6_ready_after", issue_ready_o, 1'b1);
    chk("t6_valid_after", result_valid_o, 1'b0);
    tick();
    for (int i = 0; i < DEPTH; i++)
      issue(enc(3'b000, 5'(i + 20)), 64'(i), 64'd1, 3'(i), 1'b1, 1'b1);
    #1;
    chk("t6_full_after_depth", issue_ready_o, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      commit(3'(i), 1'b0, 1'b1, 64'(i + 1), 5'(i + 20));
    drain();

    repeat (3) tick();
    chk("leftover_expected", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
